// File: rtl/serial_subtractor_if.sv
// Start/operand/result bundle for the bit-serial subtractor.
// master: requester drives start/a/b/bin; slave: subtractor returns busy/done/diff/bout.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell, WIDTH+1 cycle latency.
// Ports: clk, rst_n (sync, active-low), bus (slave: start/a/b/bin in, busy/done/diff/bout out).
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_subtractor_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
   logic [CW-1:0]    cnt_q;

   logic             accept;
   logic             shift_en;
   logic             d_bit;
   logic             borrow_nxt;
   logic             last_bit;

   // full-subtractor cell on the current LSBs
   assign d_bit      = a_q[0] ^ b_q[0] ^ borrow_q;
   assign borrow_nxt = (~a_q[0] & b_q[0])
                     | (~(a_q[0] ^ b_q[0]) & borrow_q);
   assign last_bit   = (cnt_q == LAST);

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      shift_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            shift_en = 1'b1;
            if (last_bit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            borrow_q <= bus.bin;
            diff_q   <= '0;
            cnt_q    <= '0;
         end else if (shift_en) begin
            // result enters at the MSB so bit 0 lands at diff[0] after WIDTH shifts
            diff_q   <= {d_bit, diff_q[WIDTH-1:1]};
            a_q      <= {1'b0, a_q[WIDTH-1:1]};
            b_q      <= {1'b0, b_q[WIDTH-1:1]};
            borrow_q <= borrow_nxt;
            cnt_q    <= cnt_q + 1'b1;
         end
      end
   end

   // diff/bout are live registers; only meaningful while done is high or after
   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.diff = diff_q;
   assign bus.bout = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized/directed bench for serial_subtractor at WIDTH=8 and WIDTH=3.
// Expected results come from plain integer subtraction in the bench.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(3)) bus3 ();

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   serial_subtractor #(.WIDTH(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // {bout, diff} as a (w+1)-bit two's-complement of a - b - bin
   function automatic logic [31:0] ref_sub(input int w, input int a,
                                           input int b, input int bin);
      int r;
      r = a - b - bin;
      return 32'(r & ((1 << (w + 1)) - 1));
   endfunction

   function automatic logic [31:0] res8();
      return {23'd0, bus8.bout, bus8.diff};
   endfunction

   function automatic logic [31:0] res3();
      return {28'd0, bus3.bout, bus3.diff};
   endfunction

   // one WIDTH=8 operation; optionally fires a second start mid-run
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic bin, input bit mid_start);
      logic [31:0] exp;
      int busy_n;
      int done_n;
      int done_at;
      busy_n  = 0;
      done_n  = 0;
      done_at = 0;
      exp = ref_sub(8, int'(a), int'(b), int'(bin));
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.a     = a;
      bus8.b     = b;
      bus8.bin   = bin;
      @(posedge clk);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         check("busy_done_excl", 32'(bus8.busy & bus8.done), 32'd0);
         if (bus8.busy) busy_n++;
         if (bus8.done) begin
            done_n++;
            done_at = i;
            check("result8", res8(), exp);
         end
         bus8.start = (mid_start && i == 3);
         bus8.a     = 8'($urandom);
         bus8.b     = 8'($urandom);
         bus8.bin   = 1'($urandom);
      end
      check("latency8", 32'(done_at), 32'd9);
      check("busy_cycles8", 32'(busy_n), 32'd8);
      check("done_pulses8", 32'(done_n), 32'd1);
      check("hold8", res8(), exp);
   endtask

   task automatic op3(input int a, input int b, input int bin);
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      bus3.start = 1'b1;
      bus3.a     = 3'(a);
      bus3.b     = 3'(b);
      bus3.bin   = 1'(bin);
      @(posedge clk);
      @(negedge clk);
      bus3.start = 1'b0;
      bus3.a     = 3'($urandom);
      bus3.b     = 3'($urandom);
      for (int i = 2; i <= 8 && !seen; i++) begin
         @(negedge clk);
         if (bus3.done) begin
            seen = 1'b1;
            check("result3", res3(), ref_sub(3, a, b, bin));
         end
      end
      if (!seen) check("timeout3", 32'd0, 32'd1);
   endtask

   task automatic reset_mid_run();
      int done_n;
      done_n = 0;
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.a     = 8'hC3;
      bus8.b     = 8'h1A;
      bus8.bin   = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         bus8.start = 1'b0;
      end
      check("busy_before_rst", 32'(bus8.busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(bus8.busy), 32'd0);
      check("rst_done", 32'(bus8.done), 32'd0);
      check("rst_result", res8(), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus8.done) done_n++;
      end
      check("no_done_after_rst", 32'(done_n), 32'd0);
   endtask

   // start held high: one op every 10 cycles, operands change every cycle
   task automatic back_to_back();
      logic [16:0] ops [0:31];
      int dones [$];
      for (int t = 0; t < 32; t++) ops[t] = 17'($urandom);
      @(negedge clk);
      bus8.start = 1'b1;
      {bus8.bin, bus8.a, bus8.b} = ops[0];
      for (int t = 0; t < 30; t++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus8.done) begin
            dones.push_back(t);
            if (t >= 8)
               check("b2b_result", res8(),
                     ref_sub(8, int'(ops[t-8][15:8]), int'(ops[t-8][7:0]),
                             int'(ops[t-8][16])));
         end
         if (t == 29) bus8.start = 1'b0;
         else {bus8.bin, bus8.a, bus8.b} = ops[t+1];
      end
      check("b2b_count", 32'(dones.size()), 32'd3);
      if (dones.size() == 3) begin
         check("b2b_first", 32'(dones[0]), 32'd8);
         check("b2b_gap1", 32'(dones[1] - dones[0]), 32'd10);
         check("b2b_gap2", 32'(dones[2] - dones[1]), 32'd10);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      rst_n      = 1'b0;
      bus8.start = 1'b1;
      bus8.a     = 8'h55;
      bus8.b     = 8'h11;
      bus8.bin   = 1'b0;
      bus3.start = 1'b1;
      bus3.a     = 3'd5;
      bus3.b     = 3'd1;
      bus3.bin   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy8", 32'(bus8.busy), 32'd0);
      check("rst_done8", 32'(bus8.done), 32'd0);
      check("rst_res8", res8(), 32'd0);
      check("rst_busy3", 32'(bus3.busy), 32'd0);
      bus8.start = 1'b0;
      bus3.start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy8", 32'(bus8.busy), 32'd0);

      op8(8'h05, 8'h03, 1'b0, 1'b0);
      op8(8'h03, 8'h05, 1'b0, 1'b0);
      op8(8'h00, 8'h00, 1'b1, 1'b0);
      op8(8'hFF, 8'hFF, 1'b1, 1'b0);
      op8(8'hFF, 8'h00, 1'b0, 1'b0);
      op8(8'h80, 8'h7F, 1'b1, 1'b1);
      for (int k = 0; k < 6; k++)
         op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));

      reset_mid_run();
      op8(8'h9C, 8'h2B, 1'b1, 1'b0);

      back_to_back();

      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            for (int c = 0; c < 2; c++)
               op3(a, b, c);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: minuend; captured when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend; captured when start is accepted.
REQ-007 SHALL have port bin, input, 1 bit: borrow-in to the LSB; captured when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 SHALL have port diff, output, WIDTH bits: result a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout, output, 1 bit: borrow-out from the MSB; 1 when a < b + bin (unsigned).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL load a and b into shift registers, load borrow with bin, clear the bit counter and the diff shift register, then go to RUN.
REQ-014 IDLE with start=0 SHALL stay in IDLE and hold diff and bout.
REQ-015 RUN SHALL process one bit per cycle, LSB first, with a single full-subtractor cell.
REQ-016 The RUN cell SHALL compute d = a0 ^ b0 ^ borrow.
REQ-017 The RUN cell SHALL compute next borrow = (~a0 & b0) | (~(a0 ^ b0) & borrow).
REQ-018 In RUN, d SHALL shift into the diff register at the MSB (right shift), the operand registers SHALL shift right, and the counter SHALL increment.
REQ-019 RUN SHALL end after exactly WIDTH bit-cycles and then go to DONE; the counter SHALL be $clog2(WIDTH)+1 bits with no wrap before the terminal count.
REQ-020 DONE SHALL assert done for exactly one cycle, present the final diff and bout (bout = the final borrow), and go to IDLE on the next edge.
REQ-021 Latency: start accepted at edge N SHALL produce done high in the cycle after edge N+WIDTH, which is WIDTH+1 cycles after acceptance.
REQ-022 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; busy and done SHALL never be high together.
REQ-023 start in RUN or DONE SHALL be ignored, with no queuing and no effect on the result in progress.
REQ-024 start held high continuously SHALL start a new operation on each return to IDLE, giving one result per WIDTH+2 cycles.
REQ-025 diff and bout SHALL hold their last result from DONE until the next accepted start.
REQ-026 diff and bout SHALL show partial values during RUN, and the downstream stage SHALL qualify them with done.
REQ-027 Input changes on a, b or bin after acceptance SHALL NOT affect the result.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE.
REQ-029 Reset SHALL drive busy=0, done=0, diff=0 and bout=0.
REQ-030 Reset SHALL clear the counter, the operand registers and the borrow register.
REQ-031 Reset during RUN or DONE SHALL abort the operation, with no done pulse.
REQ-032 start SHALL be ignored in any cycle where rst_n=0.
REQ-033 The first start SHALL be accepted at the first edge with rst_n=1 and start=1.

Verification
REQ-034 WIDTH=8, a=0x05, b=0x03, bin=0 -> done at 9 cycles after acceptance, diff=0x02, bout=0, busy high for exactly 8 cycles.
REQ-035 WIDTH=8, a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
REQ-036 WIDTH=8, start pulsed again in mid-RUN with different operands -> ignored; first result correct; exactly one done pulse.
REQ-037 WIDTH=8, rst_n=0 for 1 cycle at bit-cycle 4 -> IDLE, all outputs 0, no done pulse; the next start completes correctly.
REQ-038 WIDTH=3, all 128 combinations of a, b and bin -> {bout, diff} equals (a - b - bin) mod 16, i.e. a 4-bit two's-complement borrow and difference.
REQ-039 WIDTH=8, start held high for 3 results -> done pulses spaced 10 cycles apart; each result matches its operands captured at acceptance.
